// File: rtl/parser_mensaje_pkg.sv
// Shared definitions for the ASCII telemetry frame, common to the receive parser and
// the transmit-side message composer.
package parser_mensaje_pkg;

  localparam logic [7:0] SIGNO_POSITIVO_DEF = 8'd33;
  localparam logic [7:0] SIGNO_NEGATIVO_DEF = 8'd35;
  localparam logic [7:0] ASCII_CERO         = 8'd48;
  localparam logic [7:0] ASCII_NUEVE        = 8'd57;

  localparam logic [1:0] EST_ESPERA_SIGNO = 2'd0;
  localparam logic [1:0] EST_DIGITO       = 2'd1;
  localparam logic [1:0] EST_TERMINADOR   = 2'd2;

  typedef enum logic [1:0] {
    ESPERA_SIGNO = EST_ESPERA_SIGNO,
    DIGITO       = EST_DIGITO,
    TERMINADOR   = EST_TERMINADOR
  } estado_t;

  function automatic logic es_signo(input logic [7:0] dato,
                                    input logic [7:0] pos,
                                    input logic [7:0] neg);
    return (dato == pos) || (dato == neg);
  endfunction

endpackage

// File: rtl/parser_mensaje_validador_digito_ascii.sv
// Combinational ASCII digit check: flags '0'..'9' and returns the binary value of the digit.
module validador_digito_ascii
  import parser_mensaje_pkg::*;
(
  input  logic [7:0] dato,
  output logic       es_digito,
  output logic [3:0] nibble
);

  // ASCII_CERO is 8'h30, so for a digit the low nibble already equals byte - ASCII_CERO
  always_comb begin
    if ((dato >= ASCII_CERO) && (dato <= ASCII_NUEVE)) begin
      es_digito = 1'b1;
      nibble    = dato[3:0];
    end else begin
      es_digito = 1'b0;
      nibble    = 4'd0;
    end
  end

endmodule

// File: rtl/parser_mensaje.sv
// Receive-side decoder for the 6-byte ASCII telemetry frame: sign, four BCD digits
// (least significant first) and a terminator.
module parser_mensaje
  import parser_mensaje_pkg::*;
#(
  parameter logic [7:0]  signo_positivo = SIGNO_POSITIVO_DEF,
  parameter logic [7:0]  signo_negativo = SIGNO_NEGATIVO_DEF,
  parameter int unsigned TIMEOUT_CICLOS = 50000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic [7:0]  caracter_terminacion,
  output logic [15:0] BCD,
  output logic        signo,
  output logic        mensaje_valido,
  output logic        error_trama,
  output logic        ocupado
);

  localparam int unsigned TW = (TIMEOUT_CICLOS > 32'd0) ? $clog2(TIMEOUT_CICLOS + 32'd1) : 1;
  localparam logic [TW-1:0] TIMER_MAX    = TW'(TIMEOUT_CICLOS);
  localparam logic [TW-1:0] TIMER_ULTIMO = (TIMEOUT_CICLOS > 32'd0) ? TW'(TIMEOUT_CICLOS - 32'd1)
                                                                     : TW'(0);

  estado_t        estado_r;
  logic [1:0]     idx_r;
  logic [15:0]    sombra_r;
  logic           signo_sombra_r;
  logic [TW-1:0]  timer_r;

  logic           es_signo_s;
  logic           es_positivo_s;
  logic           es_digito_s;
  logic [3:0]     nibble_s;
  logic           expira_s;

  validador_digito_ascii u_validador (
    .dato      (rx_data),
    .es_digito (es_digito_s),
    .nibble    (nibble_s)
  );

  assign es_signo_s    = es_signo(rx_data, signo_positivo, signo_negativo);
  assign es_positivo_s = (rx_data == signo_positivo);

  // Expiry: the idle cycle in which the count would reach TIMEOUT_CICLOS; a byte in that cycle wins
  always_comb begin
    if ((TIMEOUT_CICLOS != 32'd0) && ocupado && !rx_valid && (timer_r == TIMER_ULTIMO)) begin
      expira_s = 1'b1;
    end else begin
      expira_s = 1'b0;
    end
  end

  // Inter-byte timer: cleared by every byte, counts (saturating) while a frame is open
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timer_r <= '0;
    end else if (rx_valid || expira_s) begin
      timer_r <= '0;
    end else if (ocupado && (timer_r != TIMER_MAX)) begin
      timer_r <= timer_r + TW'(1);
    end else begin
      timer_r <= timer_r;
    end
  end

  // Frame FSM with index, shadow register and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_r       <= ESPERA_SIGNO;
      idx_r          <= 2'd0;
      sombra_r       <= 16'h0000;
      signo_sombra_r <= 1'b1;
      BCD            <= 16'h0000;
      signo          <= 1'b1;
      mensaje_valido <= 1'b0;
      error_trama    <= 1'b0;
      ocupado        <= 1'b0;
    end else begin
      mensaje_valido <= 1'b0;
      error_trama    <= 1'b0;
      if (rx_valid) begin
        case (estado_r)
          ESPERA_SIGNO: begin
            if (es_signo_s) begin
              signo_sombra_r <= es_positivo_s;
              idx_r          <= 2'd0;
              estado_r       <= DIGITO;
              ocupado        <= 1'b1;
            end
          end
          DIGITO: begin
            if (es_digito_s) begin
              sombra_r[{idx_r, 2'b00} +: 4] <= nibble_s;
              idx_r <= idx_r + 2'd1;
              if (idx_r == 2'd3) begin
                estado_r <= TERMINADOR;
              end
            end else begin
              error_trama <= 1'b1;
              // a sign character aborts the frame but also opens the next one
              if (es_signo_s) begin
                signo_sombra_r <= es_positivo_s;
                idx_r          <= 2'd0;
                estado_r       <= DIGITO;
                ocupado        <= 1'b1;
              end else begin
                estado_r <= ESPERA_SIGNO;
                ocupado  <= 1'b0;
              end
            end
          end
          TERMINADOR: begin
            if (rx_data == caracter_terminacion) begin
              BCD            <= sombra_r;
              signo          <= signo_sombra_r;
              mensaje_valido <= 1'b1;
              estado_r       <= ESPERA_SIGNO;
              ocupado        <= 1'b0;
            end else begin
              error_trama <= 1'b1;
              if (es_signo_s) begin
                signo_sombra_r <= es_positivo_s;
                idx_r          <= 2'd0;
                estado_r       <= DIGITO;
                ocupado        <= 1'b1;
              end else begin
                estado_r <= ESPERA_SIGNO;
                ocupado  <= 1'b0;
              end
            end
          end
          default: begin
            estado_r <= ESPERA_SIGNO;
            ocupado  <= 1'b0;
          end
        endcase
      end else if (expira_s) begin
        error_trama <= 1'b1;
        estado_r    <= ESPERA_SIGNO;
        ocupado     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_parser_mensaje.sv
// Self-checking bench for parser_mensaje: directed frames followed by random traffic,
// compared every cycle against a frame-level reference model.
module tb_parser_mensaje;

  localparam int TO = 10;

  logic        clock;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  caracter_terminacion;
  logic [15:0] bcd;
  logic        signo;
  logic        mensaje_valido;
  logic        error_trama;
  logic        ocupado;

  int checks = 0;
  int errors = 0;

  // reference model: position in frame (0 = idle, 1..4 = expecting digit n, 5 = terminator)
  int          m_pos;
  int          m_dig [4];
  bit          m_sg;
  int          m_cnt;
  logic [15:0] e_bcd;
  logic        e_sg;
  logic        e_mv;
  logic        e_err;

  parser_mensaje #(
    .signo_positivo (8'd33),
    .signo_negativo (8'd35),
    .TIMEOUT_CICLOS (TO)
  ) dut (
    .clock                (clock),
    .reset_n              (reset_n),
    .rx_data              (rx_data),
    .rx_valid             (rx_valid),
    .caracter_terminacion (caracter_terminacion),
    .BCD                  (bcd),
    .signo                (signo),
    .mensaje_valido       (mensaje_valido),
    .error_trama          (error_trama),
    .ocupado              (ocupado)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_cnt = 0; m_sg = 1'b1;
    e_bcd = 16'h0000; e_sg = 1'b1; e_mv = 1'b0; e_err = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic [7:0] t);
    bit is_sg;
    bit is_dg;
    is_sg = (d == 8'd33) || (d == 8'd35);
    is_dg = (d >= 8'd48) && (d <= 8'd57);
    e_mv = 1'b0;
    e_err = 1'b0;
    if (v) begin
      m_cnt = 0;
      if (m_pos == 0) begin
        if (is_sg) begin m_pos = 1; m_sg = (d == 8'd33); end
      end else if (m_pos <= 4 && is_dg) begin
        m_dig[m_pos-1] = int'(d) - 48;
        m_pos++;
      end else if (m_pos == 5 && d == t) begin
        e_bcd = 16'(m_dig[0] + m_dig[1] * 16 + m_dig[2] * 256 + m_dig[3] * 4096);
        e_sg  = m_sg;
        e_mv  = 1'b1;
        m_pos = 0;
      end else begin
        e_err = 1'b1;
        if (is_sg) begin m_pos = 1; m_sg = (d == 8'd33); end
        else m_pos = 0;
      end
    end else if (m_pos != 0) begin
      m_cnt++;
      if (m_cnt == TO) begin e_err = 1'b1; m_pos = 0; m_cnt = 0; end
    end
  endtask

  task automatic cycle(input logic v, input logic [7:0] d, input logic [7:0] t);
    rx_valid = v;
    rx_data = d;
    caracter_terminacion = t;
    @(posedge clock);
    model_step(v, d, t);
    @(negedge clock);
    chk("bcd", bcd, e_bcd);
    chk("signo", signo, e_sg);
    chk("mensaje_valido", mensaje_valido, e_mv);
    chk("error_trama", error_trama, e_err);
    chk("ocupado", ocupado, (m_pos != 0));
    chk("pulse_exclusive", mensaje_valido & error_trama, 1'b0);
  endtask

  task automatic tx(input logic [7:0] d, input logic [7:0] t);
    cycle(1'b1, d, t);
  endtask

  task automatic idle(input int n, input logic [7:0] t);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, t);
  endtask

  initial begin
    logic [7:0] term;
    logic [7:0] b;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    caracter_terminacion = 8'h0D;
    reset_n = 1'b1;
    model_reset();
    #1 reset_n = 1'b0;
    #2;
    chk("rst_bcd", bcd, 16'h0000);
    chk("rst_signo", signo, 1'b1);
    chk("rst_mv", mensaje_valido, 1'b0);
    chk("rst_err", error_trama, 1'b0);
    chk("rst_ocupado", ocupado, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;

    // 1: positive frame, CR terminator
    tx(8'd33, 8'h0D); tx("4", 8'h0D); tx("3", 8'h0D); tx("2", 8'h0D); tx("1", 8'h0D);
    tx(8'h0D, 8'h0D);
    chk("t1_bcd", bcd, 16'h1234);
    chk("t1_mv", mensaje_valido, 1'b1);
    idle(1, 8'h0D);
    chk("t1_mv_one_cycle", mensaje_valido, 1'b0);

    // 2: negative frame, LF terminator
    tx(8'd35, 8'h0A); tx("9", 8'h0A); tx("0", 8'h0A); tx("0", 8'h0A); tx("0", 8'h0A);
    tx(8'h0A, 8'h0A);
    chk("t2_bcd", bcd, 16'h0009);
    chk("t2_signo", signo, 1'b0);

    // 3: bad digit aborts, value held; then good frame
    tx(8'd33, 8'h0D); tx("1", 8'h0D); tx("A", 8'h0D);
    chk("t3_err", error_trama, 1'b1);
    chk("t3_hold", bcd, 16'h0009);
    tx(8'd35, 8'h0D); tx("5", 8'h0D); tx("5", 8'h0D); tx("5", 8'h0D); tx("5", 8'h0D);
    tx(8'h0D, 8'h0D);
    chk("t3_bcd", bcd, 16'h5555);

    // 4: sign in the middle restarts the frame
    tx(8'd33, 8'h0D); tx("1", 8'h0D); tx("2", 8'h0D); tx(8'd33, 8'h0D);
    chk("t4_err", error_trama, 1'b1);
    chk("t4_busy", ocupado, 1'b1);
    tx("8", 8'h0D); tx("7", 8'h0D); tx("6", 8'h0D); tx("5", 8'h0D); tx(8'h0D, 8'h0D);
    chk("t4_bcd", bcd, 16'h5678);
    chk("t4_signo", signo, 1'b1);

    // 5: timeout after TO idle cycles, and a byte arriving in the expiry cycle
    tx(8'd33, 8'h0D); tx("3", 8'h0D);
    idle(TO - 1, 8'h0D);
    chk("t5_not_yet", error_trama, 1'b0);
    idle(1, 8'h0D);
    chk("t5_timeout_err", error_trama, 1'b1);
    chk("t5_timeout_idle", ocupado, 1'b0);
    tx(8'd33, 8'h0D); tx("3", 8'h0D);
    idle(TO - 1, 8'h0D);
    tx("4", 8'h0D);
    chk("t5_byte_wins", error_trama, 1'b0);
    tx("2", 8'h0D); tx("1", 8'h0D); tx(8'h0D, 8'h0D);
    chk("t5_bcd", bcd, 16'h1243);

    // 6: garbage while idle, then reset mid-frame
    tx(8'h41, 8'h0D); tx(8'h20, 8'h0D);
    tx(8'd35, 8'h0D); tx("7", 8'h0D);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_bcd", bcd, 16'h0000);
    chk("t6_rst_signo", signo, 1'b1);
    chk("t6_rst_ocupado", ocupado, 1'b0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    tx("1", 8'h0D);
    chk("t6_digit_ignored", ocupado, 1'b0);

    // random traffic: mostly valid frames, sporadic corruption and long gaps
    for (int f = 0; f < 300; f++) begin
      term = 8'($urandom_range(0, 255));
      for (int k = 0; k < 6; k++) begin
        if (k == 0) b = ($urandom_range(0, 1) != 0) ? 8'd33 : 8'd35;
        else if (k < 5) b = 8'(48 + $urandom_range(0, 9));
        else b = term;
        if ($urandom_range(0, 15) == 0) b = 8'($urandom_range(0, 255));
        tx(b, term);
        if ($urandom_range(0, 24) == 0) idle($urandom_range(TO - 1, TO + 1), term);
        else idle($urandom_range(0, 2), term);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
